// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES key-expansion write side and its consumers.
// Key-length encodings, store geometry and the key_len -> last round index map.
package aes_key_pkg;

    localparam int NUM_RK = 15;
    localparam int KW     = 128;
    localparam int AW     = 4;

    localparam logic [1:0] KEY_LEN_NONE = 2'b00;
    localparam logic [1:0] KEY_LEN_128  = 2'b01;
    localparam logic [1:0] KEY_LEN_192  = 2'b10;
    localparam logic [1:0] KEY_LEN_256  = 2'b11;

    function automatic logic [AW-1:0] last_idx_of(input logic [1:0] key_len);
        logic [AW-1:0] idx;
        case (key_len)
            KEY_LEN_128: idx = 4'd10;
            KEY_LEN_192: idx = 4'd12;
            KEY_LEN_256: idx = 4'd14;
            default:     idx = 4'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/round_key_store.sv
// Round-key store: captures subkeys from the expander and serves reads to the
// cipher datapath, stalling a read until its key has been written.
module round_key_store #(
    parameter int NUM_RK = aes_key_pkg::NUM_RK,
    parameter int KW     = aes_key_pkg::KW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    key_len,
    input  logic          clr_valid,
    input  logic          wr_valid,
    input  logic [3:0]    wr_addr,
    input  logic [KW-1:0] wr_data,
    input  logic          rd_req,
    input  logic [3:0]    rd_addr,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [KW-1:0] rd_data,
    output logic          rd_err,
    output logic [3:0]    last_idx,
    output logic          keys_ready
);
    import aes_key_pkg::KEY_LEN_NONE;
    import aes_key_pkg::last_idx_of;

    typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;

    localparam logic [4:0] NUM_RK_W = 5'(NUM_RK);

    logic [KW-1:0]     mem [NUM_RK];
    logic [NUM_RK-1:0] vbit_reg;
    logic [NUM_RK-1:0] wr_sel;
    logic [NUM_RK-1:0] in_range;
    logic [15:0]       vbit_pad;

    logic [1:0]    key_len_reg;
    logic [3:0]    last_idx_reg;
    logic          keys_ready_reg;

    rd_state_t     state_reg, state_next;
    logic [3:0]    addr_reg, addr_next;
    logic          rd_valid_reg, rd_valid_next;
    logic          rd_err_reg, rd_err_next;
    logic [KW-1:0] rd_data_reg, rd_data_next;

    logic          wr_en;
    logic [3:0]    sel_addr;
    logic [3:0]    sel_idx;
    logic          fwd_hit;
    logic          stored_hit;
    logic          hit;
    logic          out_of_range;
    logic [KW-1:0] hit_data;
    logic          all_valid;

    assign wr_en = wr_valid && ({1'b0, wr_addr} < NUM_RK_W);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A write in the same cycle as a clear keeps its bit: clear masks only the old state.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RK; gi++) begin : g_vbit
            assign wr_sel[gi]   = wr_en && (wr_addr == 4'(gi));
            assign in_range[gi] = (4'(gi) <= last_idx_reg);

            always_ff @(posedge clk) begin
                if (reset) begin
                    vbit_reg[gi] <= 1'b0;
                end else begin
                    vbit_reg[gi] <= wr_sel[gi] | (vbit_reg[gi] & ~clr_valid);
                end
            end
        end
    endgenerate

    assign all_valid = &(vbit_reg | ~in_range);
    assign vbit_pad  = 16'(vbit_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            key_len_reg    <= KEY_LEN_NONE;
            last_idx_reg   <= 4'd0;
            keys_ready_reg <= 1'b0;
        end else begin
            if (clr_valid) begin
                key_len_reg  <= key_len;
                last_idx_reg <= last_idx_of(key_len);
            end
            keys_ready_reg <= !clr_valid && (key_len_reg != KEY_LEN_NONE) && all_valid;
        end
    end

    // Lookup path shared by a fresh request and a parked one.
    assign sel_addr     = (state_reg == RD_IDLE) ? rd_addr : addr_reg;
    assign sel_idx      = ({1'b0, sel_addr} < NUM_RK_W) ? sel_addr : 4'd0;
    assign fwd_hit      = wr_en && (wr_addr == sel_addr);
    assign stored_hit   = !clr_valid && vbit_pad[sel_addr];
    assign hit          = fwd_hit || stored_hit;
    assign out_of_range = sel_addr > last_idx_reg;
    assign hit_data     = fwd_hit ? wr_data : mem[sel_idx];

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        rd_valid_next = 1'b0;
        rd_err_next   = 1'b0;
        rd_data_next  = rd_data_reg;
        case (state_reg)
            RD_IDLE: begin
                if (rd_req) begin
                    if (out_of_range) begin
                        rd_valid_next = 1'b1;
                        rd_err_next   = 1'b1;
                        rd_data_next  = '0;
                    end else if (hit) begin
                        rd_valid_next = 1'b1;
                        rd_data_next  = hit_data;
                    end else begin
                        state_next = RD_WAIT;
                        addr_next  = rd_addr;
                    end
                end
            end
            RD_WAIT: begin
                // A clear parks the request one more cycle so it is judged against the new key length.
                if (!clr_valid) begin
                    if (out_of_range) begin
                        rd_valid_next = 1'b1;
                        rd_err_next   = 1'b1;
                        rd_data_next  = '0;
                        state_next    = RD_IDLE;
                    end else if (hit) begin
                        rd_valid_next = 1'b1;
                        rd_data_next  = hit_data;
                        state_next    = RD_IDLE;
                    end
                end
            end
            default: state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RD_IDLE;
            addr_reg     <= 4'd0;
            rd_valid_reg <= 1'b0;
            rd_err_reg   <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            rd_valid_reg <= rd_valid_next;
            rd_err_reg   <= rd_err_next;
            rd_data_reg  <= rd_data_next;
        end
    end

    assign rd_ready   = (state_reg == RD_IDLE);
    assign rd_valid   = rd_valid_reg;
    assign rd_err     = rd_err_reg;
    assign rd_data    = rd_data_reg;
    assign last_idx   = last_idx_reg;
    assign keys_ready = keys_ready_reg;

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: a behavioural key-store model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_round_key_store;

    logic         clk;
    logic         reset;
    logic [1:0]   key_len;
    logic         clr_valid;
    logic         wr_valid;
    logic [3:0]   wr_addr;
    logic [127:0] wr_data;
    logic         rd_req;
    logic [3:0]   rd_addr;
    logic         rd_ready;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         rd_err;
    logic [3:0]   last_idx;
    logic         keys_ready;

    int errors = 0;
    int checks = 0;

    round_key_store dut (
        .clk        (clk),
        .reset      (reset),
        .key_len    (key_len),
        .clr_valid  (clr_valid),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .last_idx   (last_idx),
        .keys_ready (keys_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_started = 0;
    bit           m_valid [15];
    logic [127:0] m_mem   [15];
    int           m_len;
    bit           m_pending;
    int           m_paddr;
    bit           exp_ready, exp_valid, exp_err, exp_kr;
    logic [127:0] exp_data;
    int           exp_last;

    // AES-128/192/256 have 10/12/14 rounds; the last round key index equals the round count.
    function automatic int last_for(input int len);
        return (len == 0) ? 0 : 8 + 2 * len;
    endfunction

    function automatic bit key_avail(input int a);
        bit fwd;
        fwd = wr_valid && (int'(wr_addr) == a) && (a < 15);
        return fwd || (!clr_valid && (a < 15) && m_valid[a]);
    endfunction

    function automatic logic [127:0] key_value(input int a);
        if (wr_valid && (int'(wr_addr) == a)) return wr_data;
        return (a < 15) ? m_mem[a] : '0;
    endfunction

    always @(posedge clk) begin
        int  lastn;
        int  a;
        bit  full;
        if (reset) begin
            m_started = 1;
            foreach (m_valid[i]) m_valid[i] = 0;
            m_len     = 0;
            m_pending = 0;
            exp_ready = 1; exp_valid = 0; exp_err = 0; exp_kr = 0;
            exp_data  = '0;
            exp_last  = 0;
        end else if (m_started) begin
            lastn     = last_for(m_len);
            exp_valid = 0;
            exp_err   = 0;
            if (!m_pending) begin
                if (rd_req) begin
                    a = int'(rd_addr);
                    if (a > lastn) begin
                        exp_valid = 1; exp_err = 1; exp_data = '0;
                    end else if (key_avail(a)) begin
                        exp_valid = 1; exp_data = key_value(a);
                    end else begin
                        m_pending = 1; m_paddr = a;
                    end
                end
            end else if (!clr_valid) begin
                if (m_paddr > lastn) begin
                    exp_valid = 1; exp_err = 1; exp_data = '0; m_pending = 0;
                end else if (key_avail(m_paddr)) begin
                    exp_valid = 1; exp_data = key_value(m_paddr); m_pending = 0;
                end
            end
            full = 1;
            for (int i = 0; i <= lastn; i++) if (!m_valid[i]) full = 0;
            exp_kr = !clr_valid && (m_len != 0) && full;
            if (clr_valid) begin
                foreach (m_valid[i]) m_valid[i] = 0;
                m_len = int'(key_len);
            end
            if (wr_valid && wr_addr < 15) begin
                m_valid[wr_addr] = 1;
                m_mem[wr_addr]   = wr_data;
            end
            exp_ready = !m_pending;
            exp_last  = last_for(m_len);
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("cmp rd_ready", 128'(rd_ready), 128'(exp_ready));
            chk("cmp rd_valid", 128'(rd_valid), 128'(exp_valid));
            if (exp_valid) chk("cmp rd_err", 128'(rd_err), 128'(exp_err));
            chk("cmp rd_data", rd_data, exp_data);
            chk("cmp last_idx", 128'(last_idx), 128'(exp_last));
            chk("cmp keys_ready", 128'(keys_ready), 128'(exp_kr));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a5;
        a5 = {16{8'hA5}};
        reset = 1; key_len = 2'b00; clr_valid = 0; wr_valid = 0; wr_addr = 0;
        wr_data = '0; rd_req = 0; rd_addr = 0;
        repeat (3) tick();
        chk("reset rd_ready", 128'(rd_ready), 128'd1);
        chk("reset rd_valid", 128'(rd_valid), 128'd0);
        chk("reset last_idx", 128'(last_idx), 128'd0);
        chk("reset keys_ready", 128'(keys_ready), 128'd0);
        reset = 0;

        // AES-128 expansion, indices 0..10
        clr_valid = 1; key_len = 2'b01; tick(); clr_valid = 0;
        chk("aes128 last_idx", 128'(last_idx), 128'd10);
        for (int i = 0; i <= 10; i++) begin
            wr_valid = 1; wr_addr = 4'(i); wr_data = 128'(i); tick();
        end
        wr_valid = 0;
        chk("kr one edge after last write", 128'(keys_ready), 128'd0);
        tick();
        chk("kr two edges after last write", 128'(keys_ready), 128'd1);

        // back-to-back hits
        for (int i = 0; i < 3; i++) begin
            rd_req = 1; rd_addr = 4'(i); tick();
            chk("b2b rd_valid", 128'(rd_valid), 128'd1);
            chk("b2b rd_data", rd_data, 128'(i));
            chk("b2b rd_ready", 128'(rd_ready), 128'd1);
        end
        rd_req = 0;

        // out-of-range request
        rd_req = 1; rd_addr = 4'd12; tick(); rd_req = 0;
        chk("oor rd_valid", 128'(rd_valid), 128'd1);
        chk("oor rd_err", 128'(rd_err), 128'd1);
        chk("oor rd_data", rd_data, 128'd0);

        // stalled read satisfied by forwarding
        clr_valid = 1; key_len = 2'b01; tick(); clr_valid = 0;
        chk("clear kr", 128'(keys_ready), 128'd0);
        rd_req = 1; rd_addr = 4'd5; tick(); rd_req = 0;
        chk("stall rd_ready", 128'(rd_ready), 128'd0);
        tick(); tick();
        chk("stall no rd_valid", 128'(rd_valid), 128'd0);
        wr_valid = 1; wr_addr = 4'd5; wr_data = a5; tick(); wr_valid = 0;
        chk("fwd rd_valid", 128'(rd_valid), 128'd1);
        chk("fwd rd_data", rd_data, a5);
        chk("fwd rd_ready", 128'(rd_ready), 128'd1);

        // parked request re-checked against a shorter key after a clear
        clr_valid = 1; key_len = 2'b11; tick(); clr_valid = 0;
        chk("aes256 last_idx", 128'(last_idx), 128'd14);
        rd_req = 1; rd_addr = 4'd12; tick(); rd_req = 0;
        chk("recheck parked", 128'(rd_ready), 128'd0);
        clr_valid = 1; key_len = 2'b01; tick(); clr_valid = 0;
        chk("recheck still parked", 128'(rd_ready), 128'd0);
        chk("recheck last_idx", 128'(last_idx), 128'd10);
        tick();
        chk("recheck rd_valid", 128'(rd_valid), 128'd1);
        chk("recheck rd_err", 128'(rd_err), 128'd1);
        chk("recheck rd_data", rd_data, 128'd0);

        // clear and write coincide: only entry 0 survives
        clr_valid = 1; key_len = 2'b01; wr_valid = 1; wr_addr = 4'd0;
        wr_data = 128'hDEAD_BEEF; tick(); clr_valid = 0; wr_valid = 0;
        chk("clr+wr kr", 128'(keys_ready), 128'd0);
        rd_req = 1; rd_addr = 4'd0; tick();
        chk("clr+wr entry0 hit", 128'(rd_valid), 128'd1);
        chk("clr+wr entry0 data", rd_data, 128'hDEAD_BEEF);
        rd_addr = 4'd1; tick(); rd_req = 0;
        chk("clr+wr entry1 miss", 128'(rd_ready), 128'd0);

        // reset while parked
        reset = 1; tick(); reset = 0;
        chk("reset-wait rd_valid", 128'(rd_valid), 128'd0);
        chk("reset-wait rd_ready", 128'(rd_ready), 128'd1);
        tick();
        chk("post-reset rd_valid", 128'(rd_valid), 128'd0);

        // no key: keys_ready held low even with entry 0 valid
        clr_valid = 1; key_len = 2'b00; tick(); clr_valid = 0;
        wr_valid = 1; wr_addr = 4'd0; wr_data = 128'h1; tick(); wr_valid = 0;
        tick(); tick();
        chk("none keys_ready", 128'(keys_ready), 128'd0);
        chk("none last_idx", 128'(last_idx), 128'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_key_store.md
# round_key_store

Round-key storage and read server on the consumer side of the key-expansion write interface. Captures subkeys as the expander emits them (write strobe, 4-bit address, 128-bit data, clear-valid pulse), tracks a per-entry valid bit, and serves round-key reads to the cipher datapath. A read stalls until the addressed key has been written, so encryption can start while expansion is still running.

## Interface
Parameters:
- NUM_RK, 15, number of key entries (AES-256 maximum, indices 0..14)
- KW, 128, round-key width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- key_len  in  2  01=AES-128, 10=AES-192, 11=AES-256, 00=none; sampled only when clr_valid=1
- clr_valid  in  1  one-cycle pulse: new key; clear all valid bits, latch key_len
- wr_valid  in  1  write strobe
- wr_addr  in  4  round-key index
- wr_data  in  KW  round key
- rd_req  in  1  read request, accepted when rd_ready=1
- rd_addr  in  4  requested round index
- rd_ready  out  1  store can accept a request
- rd_valid  out  1  one-cycle response strobe
- rd_data  out  KW  response data, held until next response
- rd_err  out  1  qualifies rd_valid: index beyond last round
- last_idx  out  4  10/12/14 for key_len 01/10/11, 0 for 00
- keys_ready  out  1  all entries 0..last_idx valid

## Operation
- Storage: NUM_RK x KW register array, no reset; vbit[NUM_RK-1:0] resets to 0.
- Write: on wr_valid, mem[wr_addr] <= wr_data and vbit[wr_addr] <= 1. Writes with wr_addr >= NUM_RK are dropped.
- Clear: on clr_valid, vbit <= 0 and key_len is latched. last_idx updates on the next edge.
  - If clr_valid and wr_valid coincide, the write's bit ends up set (write wins).
- Read FSM states: IDLE, WAIT.
  - rd_ready=1 in IDLE, 0 in WAIT.
  - hit = vbit[a] or (wr_valid and wr_addr==a), where a = rd_addr in IDLE and the captured address in WAIT. When clr_valid=1, only the forwarding term counts.
  - Forwarded hits return wr_data.
- IDLE, rd_req accepted:
  - rd_addr > last_idx: next cycle rd_valid=1, rd_err=1, rd_data=0. Stay in IDLE.
  - hit: next cycle rd_valid=1, rd_data=key. Stay in IDLE, so back-to-back reads are allowed.
  - miss: capture the address and go to WAIT.
- WAIT:
  - On hit, next cycle rd_valid=1 with the data; return to IDLE.
  - On clr_valid, stay in WAIT. The request is re-checked against the new last_idx; if out of range, respond with rd_err and return to IDLE.
- keys_ready: registered AND of vbit[0..last_idx]. Forced to 0 when key_len latched 00.

## Timing
- Reset values: rd_ready=1, rd_valid=0, rd_data=0, rd_err=0, last_idx=0, keys_ready=0, FSM=IDLE, vbit=0.
- Read latency: 1 cycle from acceptance on a hit. In WAIT, 1 cycle after the satisfying write, using same-cycle forwarding.
- keys_ready rises 2 cycles after the write of the final entry (vbit update, then AND register). It falls 1 cycle after clr_valid.
- Reset mid-WAIT aborts the read; no response is issued.
- rd_req while rd_ready=0 is ignored; the requester must hold it.

## Structure
- Shared package aes_key_pkg holds:
  - KEY_LEN_128/192/256/NONE encodings
  - NUM_RK, KW
  - a function mapping key_len to last_idx
- Flat module: the array, vbit vector and two-state FSM are small, so no sub-module is needed.

## Test plan
- Reset, then clr_valid with key_len=01, then write indices 0..10 with data 0x00..00+i → keys_ready=1 two cycles after the index-10 write; last_idx=10.
- With all keys valid, rd_req on addresses 0,1,2 in consecutive cycles → rd_valid for 3 consecutive cycles with matching data; rd_ready stays 1.
- rd_req addr 5 before it is written → rd_ready=0. Write addr 5 = 0xA5..A5 three cycles later → rd_valid with 0xA5..A5 in the next cycle (forwarded data).
- key_len=01, rd_req addr 12 → rd_valid=1, rd_err=1, rd_data=0 one cycle later.
- Simultaneous clr_valid and write of addr 0 → vbit[0]=1 and all other bits 0; keys_ready=0.
- Reset asserted while in WAIT → no rd_valid; rd_ready=1 the cycle after reset.
